// File: rtl/bench_scan_pkg.sv
// Shared types and constants for the benchmark output scanner.
package bench_scan_pkg;

    localparam int unsigned NUM_CH   = 8;
    localparam int unsigned CH_W     = 3;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned SETTLE_W = 4;

    localparam logic [DATA_W-1:0] CSUM_SEED = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        HOLD,
`ifdef SCAN_CSUM_EN
        CSUM,
`endif
        FINISH
    } scan_state_e;

endpackage

// File: rtl/bench_output_scanner_if.sv
// Captured-byte stream leaving the scanner: one valid/ready beat per channel.
interface bench_output_scanner_if;
    import bench_scan_pkg::*;

    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [CH_W-1:0]   m_chan;
    logic              m_last;
    logic              m_is_csum;

    modport master (
        output m_valid, m_data, m_chan, m_last, m_is_csum,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_data, m_chan, m_last, m_is_csum,
        output m_ready
    );

endinterface

// File: rtl/scan_chan_picker.sv
// Finds the lowest enabled channel above cur, or the lowest enabled channel
// overall when from_start is set.
module scan_chan_picker
    import bench_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   cur,
    input  logic              from_start,
    output logic [CH_W-1:0]   next_idx,
    output logic              found
);

    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!found && mask[i] && (from_start || (CH_W'(i) > cur))) begin
                found    = 1'b1;
                next_idx = CH_W'(i);
            end
        end
    end

endmodule

// File: rtl/bench_output_scanner.sv
// Scan engine: steps sel_out through enabled channels and streams captured bytes.
// Define SCAN_CSUM_EN to append an XOR checksum beat after the last channel.
module bench_output_scanner
    import bench_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NUM_CH-1:0]      chan_mask,
    output logic [CH_W-1:0]        sel_out,
    input  logic [DATA_W-1:0]      dut_out,
    bench_output_scanner_if.master m,
    output logic                   busy,
    output logic                   done
);

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    scan_state_e       state_q, state_n;
    logic [NUM_CH-1:0] mask_q, mask_n;
    logic [CH_W-1:0]   sel_q, sel_n;
    logic [SETTLE_W-1:0] cnt_q, cnt_n;
    logic [DATA_W-1:0] data_q, data_n;
    logic [CH_W-1:0]   chan_q, chan_n;
    logic              last_q, last_n;
    logic              valid_q, valid_n;
`ifdef SCAN_CSUM_EN
    logic [DATA_W-1:0] acc_q, acc_n;
    logic              is_csum_q, is_csum_n;
`endif

    logic              in_idle;
    logic [CH_W-1:0]   pick_idx;
    logic              pick_found;

    // In IDLE the live chan_mask is searched from scratch; otherwise the
    // latched mask is searched above the current channel.
    assign in_idle = (state_q == IDLE);

    scan_chan_picker u_picker (
        .mask       (in_idle ? chan_mask : mask_q),
        .cur        (sel_q),
        .from_start (in_idle),
        .next_idx   (pick_idx),
        .found      (pick_found)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            chan_q    <= '0;
            last_q    <= 1'b0;
            valid_q   <= 1'b0;
`ifdef SCAN_CSUM_EN
            acc_q     <= CSUM_SEED;
            is_csum_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_n;
            mask_q    <= mask_n;
            sel_q     <= sel_n;
            cnt_q     <= cnt_n;
            data_q    <= data_n;
            chan_q    <= chan_n;
            last_q    <= last_n;
            valid_q   <= valid_n;
`ifdef SCAN_CSUM_EN
            acc_q     <= acc_n;
            is_csum_q <= is_csum_n;
`endif
        end
    end

    always_comb begin
        state_n   = state_q;
        mask_n    = mask_q;
        sel_n     = sel_q;
        cnt_n     = cnt_q;
        data_n    = data_q;
        chan_n    = chan_q;
        last_n    = last_q;
        valid_n   = valid_q;
`ifdef SCAN_CSUM_EN
        acc_n     = acc_q;
        is_csum_n = is_csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    mask_n = chan_mask;
`ifdef SCAN_CSUM_EN
                    acc_n  = CSUM_SEED;
`endif
                    if (pick_found) begin
                        sel_n   = pick_idx;
                        cnt_n   = SETTLE_LOAD;
                        state_n = SETTLE;
                    end else begin
                        state_n = FINISH;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    data_n  = dut_out;
                    chan_n  = sel_q;
                    valid_n = 1'b1;
`ifdef SCAN_CSUM_EN
                    last_n    = 1'b0;
                    is_csum_n = 1'b0;
`else
                    last_n    = !pick_found;
`endif
                    state_n = HOLD;
                end else begin
                    cnt_n = cnt_q - SETTLE_W'(1);
                end
            end
            HOLD: begin
                if (valid_q && m.m_ready) begin
                    valid_n = 1'b0;
`ifdef SCAN_CSUM_EN
                    acc_n   = acc_q ^ data_q;
`endif
                    if (pick_found) begin
                        sel_n   = pick_idx;
                        cnt_n   = SETTLE_LOAD;
                        state_n = SETTLE;
                    end else begin
`ifdef SCAN_CSUM_EN
                        // Checksum beat goes out the very next cycle, so it
                        // folds in the byte just transferred here.
                        data_n    = acc_q ^ data_q;
                        chan_n    = '0;
                        last_n    = 1'b1;
                        is_csum_n = 1'b1;
                        valid_n   = 1'b1;
                        state_n   = CSUM;
`else
                        state_n   = FINISH;
`endif
                    end
                end
            end
`ifdef SCAN_CSUM_EN
            CSUM: begin
                if (valid_q && m.m_ready) begin
                    valid_n = 1'b0;
                    state_n = FINISH;
                end
            end
`endif
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign sel_out   = sel_q;
    assign m.m_valid = valid_q;
    assign m.m_data  = data_q;
    assign m.m_chan  = chan_q;
    assign m.m_last  = last_q;
    assign done      = (state_q == FINISH);
`ifdef SCAN_CSUM_EN
    assign m.m_is_csum = is_csum_q;
    assign busy        = (state_q == SETTLE) || (state_q == HOLD) || (state_q == CSUM);
`else
    assign m.m_is_csum = 1'b0;
    assign busy        = (state_q == SETTLE) || (state_q == HOLD);
`endif

endmodule

// File: tb/tb_bench_output_scanner.sv
// Directed, table-driven bench for bench_output_scanner (SETTLE_CYCLES=2).
module tb_bench_output_scanner;
    import bench_scan_pkg::*;

    localparam int unsigned S = 2;
`ifdef SCAN_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    typedef struct {
        logic [7:0]      mask;
        bit              toggle;
        bit              spam;
        int unsigned     n;
        logic [7:0][2:0] chans;
        logic [2:0]      sel_after;
    } scan_vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] chan_mask;
    logic [2:0] sel_out;
    logic [7:0] dut_out;
    logic       busy;
    logic       done;

    logic [7:0] dut_tab [8];
    logic [7:0] exp_tab [8];

    int unsigned checks = 0;
    int unsigned errors = 0;

    bench_output_scanner_if m_if ();

    bench_output_scanner #(.SETTLE_CYCLES(S)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .chan_mask (chan_mask),
        .sel_out   (sel_out),
        .dut_out   (dut_out),
        .m         (m_if),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always_comb dut_out = dut_tab[sel_out];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic scan_vec_t mk(input logic [7:0] mask, input bit toggle, input bit spam,
                                     input int unsigned n, input logic [23:0] chans,
                                     input logic [2:0] sel_after);
        scan_vec_t v;
        v.mask      = mask;
        v.toggle    = toggle;
        v.spam      = spam;
        v.n         = n;
        v.chans     = chans;
        v.sel_after = sel_after;
        return v;
    endfunction

    task automatic restore_tabs();
        for (int i = 0; i < 8; i++) dut_tab[i] = exp_tab[i];
    endtask

    task automatic run_scan(input scan_vec_t v);
        int unsigned total, beat, last_xfer, gap;
        bit          seen_done, exp_valid, exp_done, exp_busy, csum_beat;
        logic [7:0]  exp_data, acc;
        logic [2:0]  exp_chan;
        total     = (v.n != 0 && CSUM) ? v.n + 1 : v.n;
        beat      = 0;
        last_xfer = 0;
        seen_done = 1'b0;
        acc       = 8'h00;
        @(negedge clk);
        chan_mask    = v.mask;
        start        = 1'b1;
        m_if.m_ready = 1'b0;
        @(posedge clk);
        #1;
        if (!v.spam) start = 1'b0;
        for (int unsigned n = 1; n <= 200 && !seen_done; n++) begin
            @(negedge clk);
            if (v.spam) chan_mask = 8'($urandom);
            csum_beat = (beat < total) && (beat == v.n);
            gap       = csum_beat ? 0 : S;
            exp_valid = (beat < total) && (n >= last_xfer + 1 + gap);
            exp_done  = (beat == total) && (n == last_xfer + 1);
            exp_busy  = (total != 0) && !((beat == total) && (n > last_xfer));
            chk($sformatf("m_valid mask=%0h n=%0d", v.mask, n), 32'(m_if.m_valid), 32'(exp_valid));
            chk($sformatf("done mask=%0h n=%0d", v.mask, n), 32'(done), 32'(exp_done));
            chk($sformatf("busy mask=%0h n=%0d", v.mask, n), 32'(busy), 32'(exp_busy));
            exp_chan = csum_beat ? 3'd0 : v.chans[beat];
            exp_data = csum_beat ? acc : exp_tab[exp_chan];
            if (m_if.m_valid && exp_valid) begin
                chk($sformatf("m_data mask=%0h beat=%0d", v.mask, beat), 32'(m_if.m_data), 32'(exp_data));
                chk($sformatf("m_chan mask=%0h beat=%0d", v.mask, beat), 32'(m_if.m_chan), 32'(exp_chan));
                chk($sformatf("m_last mask=%0h beat=%0d", v.mask, beat), 32'(m_if.m_last),
                    32'(beat == total - 1));
                chk($sformatf("m_is_csum mask=%0h beat=%0d", v.mask, beat), 32'(m_if.m_is_csum),
                    32'(csum_beat));
            end
            m_if.m_ready = v.toggle ? n[0] : 1'b1;
            if (m_if.m_valid && m_if.m_ready) begin
                if (beat < total) begin
                    if (!csum_beat) acc = acc ^ exp_data;
                    beat++;
                end
                last_xfer = n;
            end else if (m_if.m_valid) begin
                dut_tab[sel_out] = ~dut_tab[sel_out];
            end
            seen_done = exp_done;
        end
        if (!seen_done) begin
            checks++;
            errors++;
            $display("FAIL timeout mask=%0h: got %0d beats, expected %0d", v.mask, beat, total);
        end
        @(posedge clk);
        #1;
        start        = 1'b0;
        m_if.m_ready = 1'b0;
        @(negedge clk);
        chk($sformatf("done_pulse_end mask=%0h", v.mask), 32'(done), 32'(0));
        chk($sformatf("busy_after mask=%0h", v.mask), 32'(busy), 32'(0));
        chk($sformatf("m_valid_after mask=%0h", v.mask), 32'(m_if.m_valid), 32'(0));
        chk($sformatf("sel_hold mask=%0h", v.mask), 32'(sel_out), 32'(v.sel_after));
        restore_tabs();
    endtask

    scan_vec_t vecs [6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned k;
        vecs[0] = mk(8'hFF, 1'b0, 1'b0, 8, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 3'd7);
        vecs[1] = mk(8'hA4, 1'b1, 1'b0, 3, {15'd0, 3'd7, 3'd5, 3'd2}, 3'd7);
        vecs[2] = mk(8'h00, 1'b0, 1'b0, 0, 24'd0, 3'd7);
        vecs[3] = mk(8'h12, 1'b0, 1'b1, 2, {18'd0, 3'd4, 3'd1}, 3'd4);
        vecs[4] = mk(8'h81, 1'b1, 1'b1, 2, {18'd0, 3'd7, 3'd0}, 3'd7);
        vecs[5] = mk(8'h40, 1'b1, 1'b0, 1, {21'd0, 3'd6}, 3'd6);

        for (int i = 0; i < 8; i++) exp_tab[i] = 8'h10 + 8'(i);
        restore_tabs();
        reset        = 1'b1;
        start        = 1'b0;
        chan_mask    = 8'h00;
        m_if.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst sel_out", 32'(sel_out), 32'(0));
        chk("rst m_valid", 32'(m_if.m_valid), 32'(0));
        chk("rst m_data", 32'(m_if.m_data), 32'(0));
        chk("rst m_chan", 32'(m_if.m_chan), 32'(0));
        chk("rst m_last", 32'(m_if.m_last), 32'(0));
        chk("rst m_is_csum", 32'(m_if.m_is_csum), 32'(0));
        chk("rst busy", 32'(busy), 32'(0));
        chk("rst done", 32'(done), 32'(0));
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_scan(vecs[i]);

        // Reset while a beat is stalled in HOLD.
        @(negedge clk);
        chan_mask    = 8'h0C;
        start        = 1'b1;
        m_if.m_ready = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (!m_if.m_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("hold reached m_valid", 32'(m_if.m_valid), 32'(1));
        chk("hold m_data", 32'(m_if.m_data), 32'(exp_tab[2]));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort m_valid", 32'(m_if.m_valid), 32'(0));
        chk("abort sel_out", 32'(sel_out), 32'(0));
        chk("abort busy", 32'(busy), 32'(0));
        chk("abort m_data", 32'(m_if.m_data), 32'(0));
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("abort no done c=%0d", c), 32'(done), 32'(0));
            chk($sformatf("abort idle c=%0d", c), 32'(busy), 32'(0));
            @(negedge clk);
        end
        run_scan(mk(8'h0C, 1'b0, 1'b0, 2, {18'd0, 3'd3, 3'd2}, 3'd3));

`ifdef SCAN_CSUM_EN
        exp_tab[0] = 8'hA5;
        exp_tab[1] = 8'h0F;
        restore_tabs();
        run_scan(mk(8'h03, 1'b0, 1'b0, 2, {18'd0, 3'd1, 3'd0}, 3'd1));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
